// File: rtl/dmac_nch_ctrl.sv
// dmac_nch_ctrl: multi-channel DMA controller; arbitrates channel requests, fetches per-channel config over AHB and runs the winner
module dmac_nch_ctrl #(
    parameter int NUM_CH    = 4,
    parameter int CFG_WORDS = 4,
    parameter int ARB_MODE  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            dmac_req_i,
    input  logic                         bus_grant_i,
    input  logic                         hready_i,
    input  logic [NUM_CH-1:0]            ch_done_i,
    output logic                         bus_req_o,
    output logic [NUM_CH-1:0]            req_ack_o,
    output logic [1:0]                   cfg_htrans_o,
    output logic [$clog2(CFG_WORDS)-1:0] cfg_word_sel_o,
    output logic [CFG_WORDS-1:0]         cfg_reg_en_o,
    output logic [$clog2(NUM_CH)-1:0]    ch_sel_o,
    output logic [NUM_CH-1:0]            ch_en_o,
    output logic [NUM_CH-1:0]            interrupt_o,
    output logic                         busy_o
);
    localparam int CHW = $clog2(NUM_CH);
    localparam int WSW = $clog2(CFG_WORDS);
    localparam int IW  = $clog2(CFG_WORDS + 1);
    localparam logic [IW-1:0]        LAST = IW'(CFG_WORDS);
    localparam logic [CHW-1:0]       TOP  = CHW'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0]    CH1  = NUM_CH'(1);
    localparam logic [CFG_WORDS-1:0] W1   = CFG_WORDS'(1);
    typedef enum logic [2:0] {IDLE, BUS_REQD, CFG, RUN, REGRANT} state_t;
    state_t                state_q, state_d;
    logic [NUM_CH-1:0]     pend_q, pend_d, ack, en, irq, sel_oh;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CHW-1:0]        ch_sel_q, ch_sel_d, rr_q, rr_d, win, j;
    logic [1:0]            htrans_q, htrans;
    logic [WSW-1:0]        wsel;
    logic [CFG_WORDS-1:0]  ren;
    logic                  breq, done, found;

    assign sel_oh = CH1 << ch_sel_q;
    assign done   = |(ch_done_i & sel_oh);

    always_comb begin
        win   = '0;
        j     = rr_q;
        found = 1'b0;
        if (ARB_MODE == 0) begin
            for (int k = 0; k < NUM_CH; k++) if (pend_q[k]) win = CHW'(k);
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!found && pend_q[j]) begin
                    win   = j;
                    found = 1'b1;
                end
                j = (j == TOP) ? '0 : j + CHW'(1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q | dmac_req_i;
        idx_d    = idx_q;
        ch_sel_d = ch_sel_q;
        rr_d     = rr_q;
        breq     = state_q != IDLE;
        ack      = '0;
        htrans   = 2'b00;
        wsel     = '0;
        ren      = '0;
        en       = '0;
        irq      = '0;
        case (state_q)
            IDLE: if (|pend_d) begin
                breq    = 1'b1;
                state_d = BUS_REQD;
            end
            BUS_REQD: if (bus_grant_i && hready_i) begin
                ack      = CH1 << win;
                ch_sel_d = win;
                idx_d    = '0;
                rr_d     = (win == TOP) ? '0 : win + CHW'(1);
                state_d  = CFG;
            end
            CFG: begin
                wsel = (idx_q < LAST) ? idx_q[WSW-1:0] : '0;
                if (!hready_i) htrans = htrans_q;
                else if (idx_q == LAST) begin
                    ren[CFG_WORDS-1] = 1'b1;
                    state_d          = RUN;
                end else if (bus_grant_i) begin
                    htrans = 2'b10;
                    ren    = (idx_q != '0) ? W1 << (idx_q - IW'(1)) : '0;
                    idx_d  = idx_q + IW'(1);
                end
            end
            default: begin
                en      = bus_grant_i ? sel_oh : '0;
                irq     = done ? sel_oh : '0;
                pend_d  = (pend_q | dmac_req_i) & ~irq;
                state_d = done ? IDLE : (bus_grant_i ? RUN : REGRANT);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            idx_q    <= '0;
            ch_sel_q <= '0;
            rr_q     <= '0;
            htrans_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            idx_q    <= idx_d;
            ch_sel_q <= ch_sel_d;
            rr_q     <= rr_d;
            htrans_q <= htrans;
        end
    end

    assign bus_req_o      = breq & ~rst;
    assign req_ack_o      = rst ? '0 : ack;
    assign cfg_htrans_o   = rst ? 2'b00 : htrans;
    assign cfg_word_sel_o = rst ? '0 : wsel;
    assign cfg_reg_en_o   = rst ? '0 : ren;
    assign ch_sel_o       = rst ? '0 : ch_sel_q;
    assign ch_en_o        = rst ? '0 : en;
    assign interrupt_o    = rst ? '0 : irq;
    assign busy_o         = ~rst & (state_q != IDLE);
endmodule

// File: tb/tb_dmac_nch_ctrl.sv
// tb_dmac_nch_ctrl: scoreboard bench for dmac_nch_ctrl, fixed-priority and round-robin instances on shared stimulus
module tb_dmac_nch_ctrl;
    localparam logic [2:0] K_ADDR = 3'd1, K_REN = 3'd2, K_ACK = 3'd3, K_IRQ = 3'd4, K_EN = 3'd5;
    typedef struct packed { logic [2:0] k; logic [3:0] v; } ev_t;
    logic       clk = 1'b0, rst = 1'b1, bus_grant = 1'b0, hready = 1'b1;
    logic [3:0] dmac_req = '0, ch_done = '0, prev_en = '0;
    logic       bus_req [2], busy [2];
    logic [3:0] ack [2], ren [2], en [2], irq [2];
    logic [1:0] ht [2], ws [2], csel [2];
    ev_t        exp_q [$];
    int         checks = 0, errors = 0, m = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 2; i++) begin : g_dut
        dmac_nch_ctrl #(.NUM_CH(4), .CFG_WORDS(4), .ARB_MODE(i)) u_dut (
            .clk(clk), .rst(rst), .dmac_req_i(dmac_req), .bus_grant_i(bus_grant), .hready_i(hready),
            .ch_done_i(ch_done), .bus_req_o(bus_req[i]), .req_ack_o(ack[i]), .cfg_htrans_o(ht[i]),
            .cfg_word_sel_o(ws[i]), .cfg_reg_en_o(ren[i]), .ch_sel_o(csel[i]), .ch_en_o(en[i]),
            .interrupt_o(irq[i]), .busy_o(busy[i])
        );
    end

    function automatic void push(input logic [2:0] k, input logic [3:0] v);
        exp_q.push_back({k, v});
    endfunction

    function automatic void got(input logic [2:0] k, input logic [3:0] v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected kind=%0d val=%b expected no event", k, v);
        end else begin
            e = exp_q.pop_front();
            if (e != {k, v}) begin
                errors++;
                $display("FAIL sb_event got kind=%0d val=%b expected kind=%0d val=%b", k, v, e.k, e.v);
            end
        end
    endfunction

    function automatic void chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (ht[m] == 2'b10) got(K_ADDR, {2'b00, ws[m]});
        if (ren[m] != '0) got(K_REN, ren[m]);
        if (ack[m] != '0) got(K_ACK, ack[m]);
        if (irq[m] != '0) got(K_IRQ, irq[m]);
        if (en[m] != prev_en) got(K_EN, en[m]);
        prev_en <= en[m];
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arb(input logic [3:0] w);
        bus_grant = 1'b1;
        hready    = 1'b1;
        push(K_ACK, w);
        nxt();
    endtask

    task automatic do_cfg(input int stall_at, input int drop_at);
        for (int i = 0; i <= 4; i++) begin
            if (i == stall_at) begin
                hready = 1'b0;
                repeat (3) begin
                    push(K_ADDR, 4'(i));
                    #1 chk("stall_sel", 4'(ws[m]), 4'(i));
                    chk("stall_ren", ren[m], 4'b0000);
                    nxt();
                end
                hready = 1'b1;
            end
            if (i == drop_at) begin
                bus_grant = 1'b0;
                repeat (2) begin
                    #1 chk("drop_htrans", 4'(ht[m]), 4'b0000);
                    chk("drop_busreq", 4'(bus_req[m]), 4'd1);
                    chk("drop_ren", ren[m], 4'b0000);
                    nxt();
                end
                bus_grant = 1'b1;
            end
            if (i < 4) push(K_ADDR, 4'(i));
            if (i > 0) push(K_REN, 4'b0001 << (i - 1));
            if (i == 4) begin
                #1 chk("cfg_end_htrans", 4'(ht[m]), 4'b0000);
                chk("cfg_end_ren", ren[m], 4'b1000);
            end
            nxt();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        dmac_req = 4'b1111;
        nxt();
        #1 chk("rst_busreq", 4'(bus_req[0]), 4'd0);
        chk("rst_busy", 4'(busy[0]), 4'd0);
        chk("rst_htrans", 4'(ht[0]), 4'd0);
        nxt();
        rst      = 1'b0;
        dmac_req = 4'b0101;
        #1 chk("idle_busreq", 4'(bus_req[0]), 4'd1);
        chk("idle_busy", 4'(busy[0]), 4'd0);
        nxt();
        dmac_req = '0;
        #1 chk("reqd_busreq", 4'(bus_req[0]), 4'd1);
        chk("reqd_busy", 4'(busy[0]), 4'd1);
        nxt();
        do_arb(4'b0100);
        do_cfg(-1, -1);
        push(K_EN, 4'b0100);
        #1 chk("run_chsel", 4'(csel[0]), 4'd2);
        chk("run_chen", en[0], 4'b0100);
        nxt();
        ch_done = 4'b0100;
        push(K_IRQ, 4'b0100);
        nxt();
        ch_done = '0;
        push(K_EN, 4'b0000);
        #1 chk("pend_kept_busreq", 4'(bus_req[0]), 4'd1);
        nxt();
        do_arb(4'b0001);
        do_cfg(-1, 1);
        push(K_EN, 4'b0001);
        nxt();
        bus_grant = 1'b0;
        ch_done   = 4'b0001;
        push(K_IRQ, 4'b0001);
        push(K_EN, 4'b0000);
        nxt();
        ch_done   = '0;
        bus_grant = 1'b1;
        #1 chk("done_drop_busy", 4'(busy[0]), 4'd0);
        chk("done_drop_busreq", 4'(bus_req[0]), 4'd0);
        nxt();
        dmac_req = 4'b0010;
        nxt();
        dmac_req = '0;
        do_arb(4'b0010);
        do_cfg(2, -1);
        push(K_EN, 4'b0010);
        #1 chk("stall_run_chen", en[0], 4'b0010);
        nxt();
        bus_grant = 1'b0;
        push(K_EN, 4'b0000);
        repeat (5) begin
            #1 chk("regrant_chen", en[0], 4'b0000);
            chk("regrant_busreq", 4'(bus_req[0]), 4'd1);
            nxt();
        end
        bus_grant = 1'b1;
        push(K_EN, 4'b0010);
        #1 chk("regrant_back_chen", en[0], 4'b0010);
        nxt();
        ch_done = 4'b0100;
        #1 chk("other_done_irq", irq[0], 4'b0000);
        nxt();
        ch_done = '0;
        #1 chk("other_done_busy", 4'(busy[0]), 4'd1);
        chk("other_done_chen", en[0], 4'b0010);
        ch_done = 4'b0010;
        push(K_IRQ, 4'b0010);
        nxt();
        ch_done = '0;
        push(K_EN, 4'b0000);
        nxt();
        dmac_req = 4'b1000;
        nxt();
        dmac_req = '0;
        do_arb(4'b1000);
        push(K_ADDR, 4'd0);
        nxt();
        push(K_ADDR, 4'd1);
        push(K_REN, 4'b0001);
        nxt();
        rst     = 1'b1;
        ch_done = 4'b1000;
        #1 chk("midcfg_rst_busreq", 4'(bus_req[0]), 4'd0);
        chk("midcfg_rst_busy", 4'(busy[0]), 4'd0);
        chk("midcfg_rst_htrans", 4'(ht[0]), 4'd0);
        chk("midcfg_rst_sel", 4'(ws[0]), 4'd0);
        chk("midcfg_rst_ren", ren[0], 4'b0000);
        chk("midcfg_rst_chsel", 4'(csel[0]), 4'd0);
        chk("midcfg_rst_irq", irq[0], 4'b0000);
        nxt();
        rst     = 1'b0;
        ch_done = '0;
        #1 chk("post_rst_busy", 4'(busy[0]), 4'd0);
        chk("post_rst_busreq", 4'(bus_req[0]), 4'd0);
        chk("post_rst_htrans", 4'(ht[0]), 4'd0);
        nxt();
        m   = 1;
        rst = 1'b1;
        nxt();
        nxt();
        rst       = 1'b0;
        dmac_req  = 4'b1111;
        bus_grant = 1'b1;
        hready    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) push(K_EN, 4'b0000);
            #1 chk("rr_idle_busreq", 4'(bus_req[m]), 4'd1);
            nxt();
            do_arb(4'b0001 << (k % 4));
            do_cfg(-1, -1);
            ch_done = 4'b0001 << (k % 4);
            push(K_IRQ, ch_done);
            push(K_EN, ch_done);
            #1 chk("rr_chsel", 4'(csel[m]), 4'(k % 4));
            nxt();
            ch_done = '0;
        end
        rst      = 1'b1;
        dmac_req = '0;
        push(K_EN, 4'b0000);
        nxt();
        nxt();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain %0d events never seen, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
